imem_responder: RTL and testbench

- Instruction-memory responder that answers the fetch stage's bus requests; it is the memory end of the fetch address/data interface.
- Samples fetch's address strobe and address, reads a word-addressed on-chip RAM, and returns the word with a data-valid strobe after a fixed pipeline latency.
- Supports a flush that kills all in-flight responses and acknowledges it with has_flushed.
- Has a side load port so benches and the boot loader can fill the RAM.

---
 rtl/imem_responder.sv | 129 ++++++++++++
 tb/tb_imem_responder.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// imem_responder: instruction-memory end of the fetch address/data interface.
//
// Samples the fetch request strobe/address, reads a word-addressed on-chip
// RAM on the same edge, and returns the word LATENCY cycles later with a
// data-valid strobe. A flush kills everything in flight and is acknowledged
// one cycle later on has_flushed. A side load port fills the RAM.
//
// Parameters:
//   ADDR_BITS  RAM index width (2**ADDR_BITS 32-bit words)
//   LATENCY    request-to-data_valid latency in cycles, legal range 1..8
//
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   address_enable    request strobe, one request per cycle
//   address           word address; only [ADDR_BITS-1:0] used (wraps)
//   flush             kill all in-flight requests and the one presented now
//   load_enable/load_address/load_data   RAM write port
//   data, data_valid  response word and its qualifier (data holds when idle)
//   has_flushed       one-cycle flush acknowledge
//   flush_count       (IMEM_FLUSH_COUNT_EN only) saturating count of
//                     responses killed by flush
//
// Optional feature macro: IMEM_FLUSH_COUNT_EN
module imem_responder #(
  parameter int ADDR_BITS = 10,
  parameter int LATENCY   = 2
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 address_enable,
  input  logic [31:0]          address,
  input  logic                 flush,
  input  logic                 load_enable,
  input  logic [ADDR_BITS-1:0] load_address,
  input  logic [31:0]          load_data,
  output logic [31:0]          data,
  output logic                 data_valid,
  output logic                 has_flushed
`ifdef IMEM_FLUSH_COUNT_EN
  ,
  output logic [15:0]          flush_count
`endif
);

  logic [31:0] mem_q [0:(2**ADDR_BITS)-1];

  logic [LATENCY:1]       vld_pipe_q, vld_pipe_d;
  logic [LATENCY:1][31:0] word_q;
  logic                   has_flushed_q;
  logic                   accept;

  // Upper address bits are deliberately ignored: the index wraps.
  logic unused_addr_hi;
  assign unused_addr_hi = ^address[31:ADDR_BITS];

  assign accept = address_enable & ~flush;

  // RAM write port. Not reset; a load during reset is overridden.
  always_ff @(posedge clock) begin
    if (!reset && load_enable)
      mem_q[load_address] <= load_data;
  end

  // Valid shift register; flush empties it and drops the new request.
  always_comb begin
    vld_pipe_d = '0;
    if (!flush) begin
      vld_pipe_d[1] = address_enable;
      for (int i = 2; i <= LATENCY; i++)
        vld_pipe_d[i] = vld_pipe_q[i-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_pipe_q    <= '0;
      has_flushed_q <= 1'b0;
    end else begin
      vld_pipe_q    <= vld_pipe_d;
      has_flushed_q <= flush;
    end
  end

  // Word pipeline. Stage 1 is the synchronous RAM read register; the read
  // sees the pre-write contents, giving read-before-write on a collision.
  // Words only advance behind a live valid bit, so the output word holds its
  // last value while data_valid is low (including across a flush).
  always_ff @(posedge clock) begin
    if (reset) begin
      word_q <= '0;
    end else begin
      if (accept)
        word_q[1] <= mem_q[address[ADDR_BITS-1:0]];
      for (int i = 2; i <= LATENCY; i++)
        if (vld_pipe_q[i-1] && !flush)
          word_q[i] <= word_q[i-1];
    end
  end

  assign data        = word_q[LATENCY];
  assign data_valid  = vld_pipe_q[LATENCY];
  assign has_flushed = has_flushed_q;

`ifdef IMEM_FLUSH_COUNT_EN
  // Killed responses per flush edge: live stage valid bits plus the request
  // discarded in the same cycle. Max 9 fits in 4 bits for LATENCY <= 8.
  logic [3:0]  n_killed;
  logic [16:0] cnt_sum;
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    n_killed = {3'b000, address_enable};
    for (int i = 1; i <= LATENCY; i++)
      n_killed = n_killed + {3'b000, vld_pipe_q[i]};
    cnt_sum = {1'b0, cnt_q} + {13'b0, n_killed};
    cnt_d   = cnt_q;
    if (flush)
      cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign flush_count = cnt_q;
`endif

endmodule

// File: tb/tb_imem_responder.sv
// Scoreboard bench for imem_responder. A reference model at each rising edge
// tracks a shadow RAM and a queue of accepted requests tagged with their
// accept edge; a monitor at each falling edge pops and compares whenever a
// response is due, and otherwise checks that data holds its last value.
module tb_imem_responder;
  localparam int AB = 10;
  localparam int L  = 2;

  logic          clock = 1'b0;
  logic          reset, address_enable, flush, load_enable;
  logic [31:0]   address, load_data;
  logic [AB-1:0] load_address;
  logic [31:0]   data;
  logic          data_valid, has_flushed;
`ifdef IMEM_FLUSH_COUNT_EN
  logic [15:0]   flush_count;
`endif

  imem_responder #(.ADDR_BITS(AB), .LATENCY(L)) dut (
    .clock(clock), .reset(reset), .address_enable(address_enable),
    .address(address), .flush(flush), .load_enable(load_enable),
    .load_address(load_address), .load_data(load_data),
    .data(data), .data_valid(data_valid), .has_flushed(has_flushed)
`ifdef IMEM_FLUSH_COUNT_EN
    , .flush_count(flush_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct { int e; logic [31:0] w; } req_t;
  req_t        q[$];
  logic [31:0] shadow [0:(2**AB)-1];
  int          edge_cnt = 0;
  int          last_pop_edge = -100;
  logic [31:0] exp_last = '0;
  logic        exp_hf = 1'b0;
  bit          started = 0;
  int          errors = 0, checks = 0;
`ifdef IMEM_FLUSH_COUNT_EN
  int          exp_fc = 0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", nm, act, exp, edge_cnt);
    end
  endtask

  // Reference model: what each edge does, from the behavioural rules.
  always @(posedge clock) begin
    edge_cnt++;
    if (reset) begin
      q.delete();
      exp_last = '0;
      exp_hf   = 1'b0;
      started  = 1;
`ifdef IMEM_FLUSH_COUNT_EN
      exp_fc   = 0;
`endif
    end else begin
      exp_hf = flush;
      if (flush) begin
`ifdef IMEM_FLUSH_COUNT_EN
        // Live stages: undelivered requests, the one shown last cycle,
        // plus the request discarded now.
        int n;
        n = q.size() + ((last_pop_edge == edge_cnt - 1) ? 1 : 0) + (address_enable ? 1 : 0);
        exp_fc = (exp_fc + n > 65535) ? 65535 : exp_fc + n;
`endif
        q.delete();
      end else if (address_enable) begin
        q.push_back('{edge_cnt, shadow[address[AB-1:0]]});
      end
      if (load_enable) shadow[load_address] = load_data;
    end
  end

  // Monitor: a request accepted at edge e is shown after edge e+L-1.
  always @(negedge clock) begin
    if (started) begin
      logic        ev;
      logic [31:0] ew;
      ev = 1'b0;
      ew = exp_last;
      if (q.size() > 0 && q[0].e + L - 1 == edge_cnt) begin
        ev = 1'b1;
        ew = q[0].w;
        void'(q.pop_front());
        exp_last      = ew;
        last_pop_edge = edge_cnt;
      end
      chk("data_valid", {31'b0, data_valid}, {31'b0, ev});
      chk("data", data, ew);
      chk("has_flushed", {31'b0, has_flushed}, {31'b0, exp_hf});
`ifdef IMEM_FLUSH_COUNT_EN
      chk("flush_count", {16'b0, flush_count}, exp_fc[31:0]);
`endif
    end
  end

  // One cycle of stimulus, applied at the falling edge.
  task automatic cyc(input logic ae, input logic [31:0] a, input logic fl,
                     input logic le, input logic [AB-1:0] la, input logic [31:0] ld,
                     input logic rst);
    @(negedge clock);
    address_enable = ae; address = a; flush = fl;
    load_enable = le; load_address = la; load_data = ld; reset = rst;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic req(input logic [31:0] a);
    cyc(1, a, 0, 0, 0, 0, 0);
  endtask

  initial begin
    reset = 1; address_enable = 0; address = 0; flush = 0;
    load_enable = 0; load_address = 0; load_data = 0;
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    // Fill indices 0..15; 0..3 get recognisable words.
    for (int i = 0; i < 16; i++) begin
      logic [31:0] w;
      w = (i < 4) ? (32'h11111111 * (i + 1)) : $urandom;
      cyc(0, 0, 0, 1, AB'(i), w, 0);
    end
    // Reset after load: outputs return to reset values, RAM is kept.
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(1);
    // Single request, latency.
    req(2); idle(4);
    // Streaming and wrap (0x401 -> index 1).
    req(0); req(1); req(2); req(3); req(32'h00000401); idle(4);
    // Flush with same-cycle request, then a request right after.
    req(0); req(1); cyc(1, 2, 1, 0, 0, 0, 0); req(3); idle(4);
    // Read/write collision, then the new word.
    cyc(1, 1, 0, 1, 1, 32'hDEADBEEF, 0); req(1); idle(4);
    // Reset mid-stream, request after release.
    req(0); req(1); cyc(1, 2, 0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0, 0, 1); req(2); idle(4);
    // Flush held several cycles with requests.
    req(3); cyc(1, 0, 1, 0, 0, 0, 0); cyc(1, 1, 1, 0, 0, 0, 0); cyc(0, 0, 1, 0, 0, 0, 0); req(2); idle(4);
    // Randomised traffic over the loaded indices, with aliased upper bits.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = $urandom;
      a[AB-1:0] = AB'($urandom_range(0, 15));
      cyc(($urandom % 4) != 0, a, ($urandom % 8) == 0, ($urandom % 4) == 0,
          AB'($urandom_range(0, 15)), $urandom, ($urandom % 100) == 0);
    end
    idle(6);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
